pl_load_store_unit: RTL

Load/store unit in the MEM stage of the MIPS pipeline, sitting between the EX/MEM pipeline register and `pl_data_memory`. It adds byte and halfword accesses (lb/lbu/lh/lhu/sb/sh) on top of the word-only data memory. Sub-word stores use a two-cycle read-modify-write that stalls the pipeline for one cycle. Loads are extracted and sign/zero-extended combinationally toward MEM/WB, and misaligned accesses are flagged and suppressed.

---
 rtl/pl_mem_pkg.sv | 42 ++++
 rtl/pl_load_store_unit_if.sv | 30 +++
 rtl/pl_load_align.sv | 31 +++
 rtl/pl_load_store_unit.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pl_mem_pkg.sv
// Shared types and big-endian lane helpers for the MEM-stage load/store unit.
// Sizes, FSM states, lane shift amounts and lane masks.
package pl_mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    LSU_IDLE,
    LSU_RMW_WRITE
  } lsu_state_t;

  // Byte lane k sits at bits [31-8k : 24-8k].
  function automatic logic [4:0] byte_shift(
    input logic [1:0] a
  );
    return {~a, 3'b000};
  endfunction

  function automatic logic [4:0] half_shift(
    input logic a1
  );
    return a1 ? 5'd0 : 5'd16;
  endfunction

  function automatic logic [31:0] lane_mask(
    input mem_size_t s,
    input logic [1:0] a
  );
    logic [31:0] m;
    unique case (s)
      MEM_BYTE: m = 32'h0000_00ff << byte_shift(a);
      MEM_HALF: m = 32'h0000_ffff << half_shift(a[1]);
      default:  m = 32'hffff_ffff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pl_load_store_unit_if.sv
// Bus between the load/store unit and the word-addressed data memory.
// master = load/store unit, slave = data memory.
interface pl_load_store_unit_if;

  logic        dm_enable;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_address;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;

  modport master (
    output dm_enable,
    output dm_read,
    output dm_write,
    output dm_address,
    output dm_write_data,
    input  dm_read_data
  );

  modport slave (
    input  dm_enable,
    input  dm_read,
    input  dm_write,
    input  dm_address,
    input  dm_write_data,
    output dm_read_data
  );

endinterface

// File: rtl/pl_load_align.sv
// Combinational big-endian lane extraction with sign/zero extension.
// Ports: dm_read_data, byte_addr, mem_size, mem_unsigned in; load_word out.
module pl_load_align
  import pl_mem_pkg::*;
(
  input  logic [31:0] dm_read_data,
  input  logic [1:0]  byte_addr,
  input  mem_size_t   mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] load_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = 8'(dm_read_data >> byte_shift(byte_addr));
  assign lane_h = 16'(dm_read_data >> half_shift(byte_addr[1]));

  always_comb begin
    load_word = dm_read_data;
    unique case (mem_size)
      MEM_BYTE:
        load_word = {{24{~mem_unsigned & lane_b[7]}}, lane_b};
      MEM_HALF:
        load_word = {{16{~mem_unsigned & lane_h[15]}}, lane_h};
      default:
        load_word = dm_read_data;
    endcase
  end

endmodule

// File: rtl/pl_load_store_unit.sv
// MEM-stage load/store unit: sub-word loads, RMW sub-word stores, misalign.
// Ports: clk, reset, EX/MEM request fields, load_data, stall, misaligned, dm bus.
module pl_load_store_unit
  import pl_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_read,
  input  logic        mem_write,
  input  mem_size_t   mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  pl_load_store_unit_if.master dm
);

  lsu_state_t  state_q;
  lsu_state_t  state_d;
  logic [31:0] merge_q;
  logic [31:0] addr_q;
  logic        capture;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        mis;
  logic        store;
  logic        load;
  logic [31:0] mask;
  logic [4:0]  sh;
  logic [31:0] merged;
  logic [31:0] aligned;

  assign is_byte = (mem_size == MEM_BYTE);
  assign is_half = (mem_size == MEM_HALF);
  assign is_word = ~is_byte & ~is_half;

  assign mis = (mem_read | mem_write)
             & ((is_half & address[0])
             |  (is_word & (address[1:0] != 2'b00)));

  // A store wins over a simultaneous load.
  assign store = mem_write & ~mis;
  assign load  = mem_read & ~mem_write & ~mis;

  assign mask   = lane_mask(mem_size, address[1:0]);
  assign sh     = is_byte ? byte_shift(address[1:0])
                          : half_shift(address[1]);
  assign merged = (dm.dm_read_data & ~mask)
                | ((store_data << sh) & mask);

  pl_load_align u_align (
    .dm_read_data (dm.dm_read_data),
    .byte_addr    (address[1:0]),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .load_word    (aligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LSU_IDLE;
      merge_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        merge_q <= merged;
        addr_q  <= {address[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    capture          = 1'b0;
    dm.dm_enable     = enable;
    dm.dm_read       = 1'b0;
    dm.dm_write      = 1'b0;
    dm.dm_address    = {address[31:2], 2'b00};
    dm.dm_write_data = store_data;
    stall            = 1'b0;
    misaligned       = 1'b0;
    load_data        = '0;
    unique case (state_q)
      LSU_IDLE: begin
        misaligned = mis;
        if (store) begin
          if (is_word) begin
            dm.dm_write = 1'b1;
          end else if (enable) begin
            dm.dm_read = 1'b1;
            stall      = 1'b1;
            capture    = 1'b1;
            state_d    = LSU_RMW_WRITE;
          end
        end else if (load) begin
          dm.dm_read = 1'b1;
          load_data  = aligned;
        end
      end
      LSU_RMW_WRITE: begin
        // Same instruction is held in EX/MEM; state drives the write.
        dm.dm_write      = 1'b1;
        dm.dm_address    = addr_q;
        dm.dm_write_data = merge_q;
        if (enable) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
    if (reset) begin
      dm.dm_write = 1'b0;
      stall       = 1'b0;
    end
  end

endmodule
